// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port SRAM between an instruction and a data requester,
// data-first with a starvation cap, one-cycle read latency and per-requester response skid registers.
module mem_port_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 3
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                inst_req_valid,
    output logic                inst_req_ready,
    input  logic [ADDR_W-1:0]   inst_req_addr,
    output logic                inst_rsp_valid,
    input  logic                inst_rsp_ready,
    output logic [DATA_W-1:0]   inst_rsp_data,
    input  logic                inst_flush,
    input  logic                data_req_valid,
    output logic                data_req_ready,
    input  logic [ADDR_W-1:0]   data_req_addr,
    input  logic [DATA_W/8-1:0] data_req_wen,
    input  logic [DATA_W-1:0]   data_req_wdata,
    output logic                data_rsp_valid,
    input  logic                data_rsp_ready,
    output logic [DATA_W-1:0]   data_rsp_data,
    output logic                sram_en,
    output logic [DATA_W/8-1:0] sram_wen,
    output logic [ADDR_W-1:0]   sram_addr,
    output logic [DATA_W-1:0]   sram_wdata,
    input  logic [DATA_W-1:0]   sram_rdata
);
    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0] SMAX = SW'(STARVE_MAX);

    logic              i_pend_q, i_pend_d, i_hv_q, i_hv_d;
    logic              d_pend_q, d_pend_d, d_hv_q, d_hv_d;
    logic [DATA_W-1:0] i_hold_q, i_hold_d, d_hold_q, d_hold_d;
    logic [SW-1:0]     starve_q, starve_d;
    logic              i_elig, d_elig, inst_gnt, data_gnt;

    // A flush frees the instruction side immediately so a redirect fetch can issue in the same cycle.
    always_comb begin
        i_elig         = !(i_hv_q && !inst_flush) && !(i_pend_q && !inst_flush && !inst_rsp_ready);
        d_elig         = !d_hv_q && !(d_pend_q && !data_rsp_ready);
        inst_gnt       = !reset && inst_req_valid && i_elig &&
                         (starve_q == SMAX || !(data_req_valid && d_elig));
        data_gnt       = !reset && data_req_valid && d_elig && !inst_gnt;
        inst_req_ready = inst_gnt;
        data_req_ready = data_gnt;
        sram_en        = inst_gnt || data_gnt;
        sram_wen       = data_gnt ? data_req_wen : '0;
        sram_addr      = inst_gnt ? inst_req_addr : data_req_addr;
        sram_wdata     = data_req_wdata;
        inst_rsp_valid = !reset && !inst_flush && (i_hv_q || i_pend_q);
        inst_rsp_data  = i_hv_q ? i_hold_q : sram_rdata;
        data_rsp_valid = !reset && (d_hv_q || d_pend_q);
        data_rsp_data  = d_hv_q ? d_hold_q : sram_rdata;
        i_pend_d       = inst_gnt;
        i_hv_d         = !inst_flush && (i_hv_q ? !inst_rsp_ready : (i_pend_q && !inst_rsp_ready));
        i_hold_d       = i_hv_q ? i_hold_q : sram_rdata;
        d_pend_d       = data_gnt && (data_req_wen == '0);
        d_hv_d         = d_hv_q ? !data_rsp_ready : (d_pend_q && !data_rsp_ready);
        d_hold_d       = d_hv_q ? d_hold_q : sram_rdata;
        starve_d       = (!inst_req_valid || inst_gnt) ? '0 :
                         (data_gnt && i_elig && starve_q != SMAX) ? starve_q + 1'b1 : starve_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            i_pend_q <= 1'b0;
            i_hv_q   <= 1'b0;
            d_pend_q <= 1'b0;
            d_hv_q   <= 1'b0;
            starve_q <= '0;
        end else begin
            i_pend_q <= i_pend_d;
            i_hv_q   <= i_hv_d;
            d_pend_q <= d_pend_d;
            d_hv_q   <= d_hv_d;
            starve_q <= starve_d;
        end
        i_hold_q <= i_hold_d;
        d_hold_q <= d_hold_d;
    end
endmodule
